// File: rtl/fp_to_int_if.sv
// Operand/result bundle for the float32 -> int32 converter.
interface fp_to_int_if;
  logic        in_vld;
  logic [31:0] a;
  logic        out_vld;
  logic [31:0] q;
  logic        ovf;
  logic        nan;
  logic        inexact;

  modport master (
    output in_vld, a,
    input  out_vld, q, ovf, nan, inexact
  );

  modport slave (
    input  in_vld, a,
    output out_vld, q, ovf, nan, inexact
  );
endinterface

// File: rtl/fp_to_int.sv
// Three-stage IEEE-754 single to signed int32 converter with saturation and
// status flags. RND selects truncation (0) or round-to-nearest-even (1).
module fp_to_int #(
  parameter int unsigned RND = 0
) (
  input  logic        clk,
  input  logic        rst,
  fp_to_int_if.slave  bus
);

  // Operand class decided in stage 1; LSH/RSH select the shift direction.
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NAN,
    CLS_INF,
    CLS_BIG,
    CLS_LSH,
    CLS_RSH
  } cls_e;

  logic [2:0] vld_q, vld_d;

  logic        s1_sign_q, s1_sign_d;
  cls_e        s1_cls_q,  s1_cls_d;
  logic [23:0] s1_sig_q,  s1_sig_d;
  logic [7:0]  s1_shamt_q, s1_shamt_d;

  logic        s2_sign_q, s2_sign_d;
  cls_e        s2_cls_q,  s2_cls_d;
  logic [32:0] s2_mag_q,  s2_mag_d;
  logic        s2_g_q,    s2_g_d;
  logic        s2_s_q,    s2_s_d;

  logic [31:0] q_q, q_d;
  logic        ovf_q, ovf_d;
  logic        nan_q, nan_d;
  logic        inexact_q, inexact_d;

  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic [48:0] rsh_wide;
  logic [32:0] lsh_val;
  logic        inc;
  logic [32:0] rounded;

  assign exp_in  = bus.a[30:23];
  assign frac_in = bus.a[22:0];

  // Stage 1: classify the operand and pick the shift direction and amount.
  always_comb begin
    s1_sign_d  = bus.a[31];
    s1_cls_d   = CLS_ZERO;
    s1_sig_d   = {1'b1, frac_in};
    s1_shamt_d = '0;
    if (exp_in == 8'd0) begin
      s1_cls_d = CLS_ZERO;
      s1_sig_d = {1'b0, frac_in};
    end else if (exp_in == 8'hFF) begin
      s1_cls_d = (frac_in != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_in >= 8'd159) begin
      s1_cls_d = CLS_BIG;
    end else if (exp_in >= 8'd150) begin
      s1_cls_d   = CLS_LSH;
      s1_shamt_d = exp_in - 8'd150;
    end else begin
      // Right shifts beyond 25 only move bits deeper into the sticky field,
      // so the amount is clamped to keep the guard position empty.
      s1_cls_d   = CLS_RSH;
      s1_shamt_d = (exp_in < 8'd125) ? 8'd25 : (8'd150 - exp_in);
    end
  end

  // Stage 2 shifters: a left shift for large exponents, and a right shift of
  // sig placed above a 25-bit field holding guard (bit 24) and sticky bits.
  assign rsh_wide = {s1_sig_q, 25'b0} >> s1_shamt_q;
  assign lsh_val  = {9'b0, s1_sig_q} << s1_shamt_q;

  // Stage 2: form the integer magnitude and the guard/sticky bits.
  always_comb begin
    s2_sign_d = s1_sign_q;
    s2_cls_d  = s1_cls_q;
    s2_mag_d  = '0;
    s2_g_d    = 1'b0;
    s2_s_d    = 1'b0;
    case (s1_cls_q)
      CLS_LSH: s2_mag_d = lsh_val;
      CLS_RSH: begin
        s2_mag_d = {9'b0, rsh_wide[48:25]};
        s2_g_d   = rsh_wide[24];
        s2_s_d   = |rsh_wide[23:0];
      end
      CLS_ZERO: s2_s_d = |s1_sig_q;
      default: ;
    endcase
  end

  assign inc     = (RND != 0) && s2_g_q && (s2_s_q || s2_mag_q[0]);
  assign rounded = s2_mag_q + {32'b0, inc};

  // Stage 3: round, range-check, apply the sign and set the flags.
  always_comb begin
    q_d       = '0;
    ovf_d     = 1'b0;
    nan_d     = 1'b0;
    inexact_d = 1'b0;
    case (s2_cls_q)
      CLS_NAN: nan_d = 1'b1;
      CLS_INF, CLS_BIG: begin
        q_d   = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ovf_d = 1'b1;
      end
      default: begin
        if (!s2_sign_q && (rounded > 33'h0_7FFF_FFFF)) begin
          q_d   = 32'h7FFF_FFFF;
          ovf_d = 1'b1;
        end else if (s2_sign_q && (rounded > 33'h0_8000_0000)) begin
          q_d   = 32'h8000_0000;
          ovf_d = 1'b1;
        end else begin
          q_d       = s2_sign_q ? (~rounded[31:0] + 32'd1) : rounded[31:0];
          inexact_d = s2_g_q || s2_s_q;
        end
      end
    endcase
  end

  // Valid bits follow the data through the three stages.
  always_comb begin
    vld_d = {vld_q[1:0], bus.in_vld};
  end

  // Valid pipeline and output registers; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      q_q       <= '0;
      ovf_q     <= 1'b0;
      nan_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      q_q       <= q_d;
      ovf_q     <= ovf_d;
      nan_q     <= nan_d;
      inexact_q <= inexact_d;
    end
  end

  // Internal data registers update every cycle with no reset or enable.
  always_ff @(posedge clk) begin
    s1_sign_q  <= s1_sign_d;
    s1_cls_q   <= s1_cls_d;
    s1_sig_q   <= s1_sig_d;
    s1_shamt_q <= s1_shamt_d;
    s2_sign_q  <= s2_sign_d;
    s2_cls_q   <= s2_cls_d;
    s2_mag_q   <= s2_mag_d;
    s2_g_q     <= s2_g_d;
    s2_s_q     <= s2_s_d;
  end

  assign bus.out_vld = vld_q[2];
  assign bus.q       = q_q;
  assign bus.ovf     = ovf_q;
  assign bus.nan     = nan_q;
  assign bus.inexact = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: one instance per rounding mode, shared stimulus,
// per-instance scoreboards fed from directed constants or a division-based model.
module tb_fp_to_int;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   in_cnt;
  int   out_cnt0;
  int   out_cnt1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] q;
    logic [2:0]  f;
    int          stamp;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0;
  exp_t e1;

  fp_to_int_if bus0 ();
  fp_to_int_if bus1 ();

  fp_to_int #(.RND(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fp_to_int #(.RND(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  // Reference: |x| = sig / 2^(150-exp); quotient and remainder give the
  // truncated value and the rounding decision directly. Result {ovf,nan,inexact,q}.
  function automatic logic [34:0] ref_conv(input logic [31:0] x, input bit rnd);
    bit      sgn;
    int      ex;
    longint  sig, mag, den, rem;
    bit      inx;
    logic [31:0] qv;
    sgn = x[31];
    ex  = int'(x[30:23]);
    inx = 1'b0;
    if (ex == 255) begin
      if (x[22:0] != 0) return {3'b010, 32'h0};
      return {3'b100, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    end
    if (ex == 0) return {2'b00, (x[22:0] != 0), 32'h0};
    sig = longint'(x[22:0]) + 64'd8388608;
    if (ex >= 182) mag = 64'h1_0000_0000;
    else if (ex >= 150) mag = sig << (ex - 150);
    else if (ex < 126) begin
      mag = 0;
      inx = 1'b1;
    end else begin
      den = 64'd1 << (150 - ex);
      mag = sig / den;
      rem = sig % den;
      inx = (rem != 0);
      if (rnd && ((2 * rem > den) || ((2 * rem == den) && (mag % 2 == 1)))) mag++;
    end
    if ((!sgn && mag > 64'd2147483647) || (sgn && mag > 64'd2147483648))
      return {3'b100, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    qv = sgn ? 32'(-mag) : 32'(mag);
    return {2'b00, inx, qv};
  endfunction

  task automatic present(input logic v, input logic [31:0] x);
    @(negedge clk);
    bus0.in_vld = v;
    bus0.a      = x;
    bus1.in_vld = v;
    bus1.a      = x;
  endtask

  task automatic send_dir(input logic [31:0] x, input logic [31:0] q0, input logic [2:0] f0,
                          input logic [31:0] q1, input logic [2:0] f1);
    present(1'b1, x);
    if (!rst) begin
      sb0.push_back('{a: x, q: q0, f: f0, stamp: cyc});
      sb1.push_back('{a: x, q: q1, f: f1, stamp: cyc});
      in_cnt++;
    end
  endtask

  task automatic send_rand(input logic [31:0] x);
    logic [34:0] r0, r1;
    r0 = ref_conv(x, 1'b0);
    r1 = ref_conv(x, 1'b1);
    send_dir(x, r0[31:0], r0[34:32], r1[31:0], r1[34:32]);
  endtask

  function automatic logic [31:0] rand_fp();
    int unsigned sel, ex, k;
    logic [31:0] fr, one;
    sel = $urandom_range(0, 15);
    fr  = 32'($urandom) & 32'h007F_FFFF;
    if (sel == 0) ex = 0;
    else if (sel == 1) begin
      ex = 255;
      if ($urandom_range(0, 1) == 0) fr = '0;
    end else if (sel < 5) begin
      ex  = $urandom_range(127, 149);
      k   = 150 - ex;
      one = 32'd1;
      fr  = (fr & ~((one << k) - 32'd1)) | (one << (k - 1));
    end else ex = $urandom_range(120, 162);
    return {1'($urandom), 8'(ex), fr[22:0]};
  endfunction

  // Result monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus0.out_vld === 1'b1) begin
      out_cnt0++;
      if (sb0.size() == 0) chk("spurious_vld0", 64'd1, 64'd0);
      else begin
        e0 = sb0.pop_front();
        chk($sformatf("q_rnd0 a=%h", e0.a), 64'(bus0.q), 64'(e0.q));
        chk($sformatf("flags_rnd0 a=%h", e0.a), 64'({bus0.ovf, bus0.nan, bus0.inexact}), 64'(e0.f));
        chk($sformatf("latency0 a=%h", e0.a), 64'(cyc - e0.stamp), 64'd3);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.out_vld === 1'b1) begin
      out_cnt1++;
      if (sb1.size() == 0) chk("spurious_vld1", 64'd1, 64'd0);
      else begin
        e1 = sb1.pop_front();
        chk($sformatf("q_rnd1 a=%h", e1.a), 64'(bus1.q), 64'(e1.q));
        chk($sformatf("flags_rnd1 a=%h", e1.a), 64'({bus1.ovf, bus1.nan, bus1.inexact}), 64'(e1.f));
      end
    end
  end

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0; in_cnt = 0; out_cnt0 = 0; out_cnt1 = 0;
    rst = 1'b1;
    bus0.in_vld = 1'b0; bus0.a = '0;
    bus1.in_vld = 1'b0; bus1.a = '0;
    present(1'b1, 32'h3F80_0000);
    repeat (3) present(1'b1, 32'h3F80_0000);
    chk("reset_out_vld", 64'(bus0.out_vld), 64'd0);
    chk("reset_q", 64'(bus0.q), 64'd0);
    chk("reset_flags", 64'({bus0.ovf, bus0.nan, bus0.inexact}), 64'd0);
    chk("reset_out_vld1", 64'(bus1.out_vld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus0.in_vld = 1'b0; bus1.in_vld = 1'b0;
    repeat (4) present(1'b0, 32'h0);

    // Directed values: {ovf,nan,inexact}
    send_dir(32'h3F80_0000, 32'h0000_0001, 3'b000, 32'h0000_0001, 3'b000);
    present(1'b0, 32'h0);
    send_dir(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 32'h7FFF_FF80, 3'b000);
    send_dir(32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 32'hFFFF_FFFE, 3'b001);
    send_dir(32'h4060_0000, 32'h0000_0003, 3'b001, 32'h0000_0004, 3'b001);
    send_dir(32'h3F00_0000, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);
    send_dir(32'h3F40_0000, 32'h0000_0000, 3'b001, 32'h0000_0001, 3'b001);
    send_dir(32'h3FC0_0000, 32'h0000_0001, 3'b001, 32'h0000_0002, 3'b001);
    send_dir(32'h3E80_0000, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);
    send_dir(32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100);
    send_dir(32'hCF00_0000, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000);
    send_dir(32'hCF00_0001, 32'h8000_0000, 3'b100, 32'h8000_0000, 3'b100);
    send_dir(32'h7F80_0000, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100);
    send_dir(32'hFF80_0000, 32'h8000_0000, 3'b100, 32'h8000_0000, 3'b100);
    send_dir(32'h7FC0_0000, 32'h0000_0000, 3'b010, 32'h0000_0000, 3'b010);
    send_dir(32'h8000_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 3'b000);
    send_dir(32'h0000_0001, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);
    send_dir(32'h4B00_0001, 32'h0080_0001, 3'b000, 32'h0080_0001, 3'b000);
    send_dir(32'hDF00_0000, 32'h8000_0000, 3'b100, 32'h8000_0000, 3'b100);

    // Random stream with gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) present(1'b0, 32'($urandom));
      send_rand(rand_fp());
    end
    repeat (6) present(1'b0, 32'h0);

    // Mid-stream reset: two accepted operands plus one presented under reset
    send_dir(32'h4120_0000, 32'd10, 3'b000, 32'd10, 3'b000);
    send_dir(32'h4140_0000, 32'd12, 3'b000, 32'd12, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    bus0.in_vld = 1'b1; bus0.a = 32'h4160_0000;
    bus1.in_vld = 1'b1; bus1.a = 32'h4160_0000;
    in_cnt -= sb0.size();
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    rst = 1'b0;
    bus0.in_vld = 1'b0; bus1.in_vld = 1'b0;
    chk("rst_clears_out_vld0", 64'(bus0.out_vld), 64'd0);
    chk("rst_clears_out_vld1", 64'(bus1.out_vld), 64'd0);
    repeat (6) present(1'b0, 32'h0);
    send_dir(32'h4180_0000, 32'd16, 3'b000, 32'd16, 3'b000);
    repeat (8) present(1'b0, 32'h0);

    chk("pending0", 64'(sb0.size()), 64'd0);
    chk("pending1", 64'(sb1.size()), 64'd0);
    chk("count0", 64'(out_cnt0), 64'(in_cnt));
    chk("count1", 64'(out_cnt1), 64'(in_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Pipelined IEEE-754 single-precision to signed 32-bit integer converter. It sits beside the floating-point adder in the datapath and turns float results back into two's-complement integers for integer consumers such as address generation, counters and fixed-point stages. It accepts one operand per cycle with no backpressure and has a fixed latency. Out-of-range inputs saturate, and status flags are reported alongside each result.

## Interface
- RND, default 0: rounding mode. 0 = truncate toward zero; 1 = round to nearest, ties to even.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  1  operand a valid this cycle.
- a  in  32  float32 operand: [31] sign, [30:23] biased exponent, [22:0] fraction.
- out_vld  out  1  q and flags valid this cycle.
- q  out  32  signed integer result.
- ovf  out  1  input was ±inf or out of int32 range; q saturated.
- nan  out  1  input was NaN; q = 0.
- inexact  out  1  nonzero fraction bits were discarded (finite, non-saturated results only).

## Operation
- Classification, with e = exp − 127 and sig = {1, frac} (24 bits):
  - exp==0: zero or denormal. Treated as |x|<1. q = 0. inexact = (frac!=0); RND=1 never rounds a denormal up.
  - exp==255, frac!=0: NaN. q = 0, nan = 1, ovf = 0, inexact = 0.
  - exp==255, frac==0: ±inf. q = 0x7FFFFFFF (+) or 0x80000000 (−), ovf = 1.
  - e ≥ 23: magnitude = sig << (e−23), exact, no fraction bits.
  - 0 ≤ e ≤ 22: magnitude = sig >> (23−e). Dropped bits form the fraction.
  - e < 0: magnitude = 0. The whole of sig is fraction. Guard bit = sig[23] if e = −1, else 0.
- Rounding:
  - G = most significant dropped bit; S = OR of the remaining dropped bits; L = LSB of the magnitude.
  - RND=0: no increment.
  - RND=1: increment the magnitude when G && (S || L).
  - inexact = G || S.
- Range: the magnitude after rounding is held in at least 33 bits.
  - Positive with magnitude > 2^31−1: q = 0x7FFFFFFF, ovf = 1, inexact = 0.
  - Negative with magnitude > 2^31: q = 0x80000000, ovf = 1, inexact = 0.
  - Negative with magnitude exactly 2^31: q = 0x80000000, ovf = 0.
  - Any e ≥ 32 overflows.
  - Rounding that carries into 2^31 is range-checked after the increment.
- Sign: q = sign ? −magnitude : magnitude. −0.0 gives q = 0 with no flags.
- At most one of ovf and nan is set. inexact is 0 whenever ovf or nan is 1.

## Timing
- Latency is 3 cycles: in_vld high at the edge ending cycle N produces out_vld high during cycle N+3. Throughput is 1 per cycle. Back-to-back and gapped inputs are both legal.
- Pipeline stages:
  - Stage 1: register the operand, classify, compute e and the shift amount.
  - Stage 2: barrel shift, extract G, S and L.
  - Stage 3: round, range check, negate, and register q and the flags.
- Valid travels through a 3-bit shift register. Data registers carry no enable and update every cycle.
- q and the flags are defined only while out_vld = 1. Outside that, they hold whatever data the pipeline last saw.
- Reset:
  - The valid shift register, out_vld, q, ovf, nan and inexact all reset to 0.
  - rst held high clears all in-flight operands; out_vld is 0 on the cycle after the reset edge.
  - in_vld is ignored while rst = 1.
  - The first valid result after release needs in_vld in a cycle with rst = 0, and appears 3 cycles later.

## Test plan
- Basic, RND=0: 0x3F800000 (1.0) → q = 1, no flags, out_vld exactly 3 cycles after in_vld. 0x4EFFFFFF → q = 0x7FFFFF80, exact.
- Rounding: 0xC0200000 (−2.5) → q = 0xFFFFFFFE (−2), inexact = 1 under both RND values. 0x40600000 (3.5) → 3 for RND=0, 4 for RND=1. 0x3F000000 (0.5) → 0 for RND=1. 0x3F400000 (0.75) → 0 for RND=0, 1 for RND=1. All set inexact.
- Saturation:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, ovf = 1.
  - 0xCF000000 (−2^31) → 0x80000000, ovf = 0.
  - 0x7F800000 (+inf) → 0x7FFFFFFF, ovf = 1.
  - 0xFF800000 (−inf) → 0x80000000, ovf = 1.
  - 0x4EFFFFFF + 0.5ulp boundary: 0x4F000000 − 1 ulp rounds without wrap.
- Special values: 0x7FC00000 (NaN) → q = 0, nan = 1. 0x80000000 (−0.0) → q = 0, no flags. 0x00000001 (denormal) → q = 0, inexact = 1.
- Streaming: 200 random operands with random in_vld gaps, checked against a reference model for both RND values. Requires result order preserved and a one-to-one count between in_vld pulses and out_vld pulses.
- Reset mid-stream: rst asserted for 1 cycle with 3 operands in flight → none of those 3 produce out_vld. The next accepted operand emerges 3 cycles after it is presented.
